period_meter: RTL and testbench

Measures the period and high time of a slow square wave, in `clock_in` cycles. Typical inputs are the divided clocks produced elsewhere in the design, or an external test signal. It is the receive-side counterpart of the clock divider: the divider turns a count into a waveform, and this block turns a waveform back into counts. It reports one result per input period and flags a stalled input with a timeout.

---
 rtl/period_meter_pkg.sv | 20 ++
 rtl/period_meter_edge_sync.sv | 55 +++++
 rtl/period_meter.sv | 104 ++++++++++
 tb/tb_period_meter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared state encoding and default sizing for period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package period_meter_pkg;

    typedef enum logic [0:0] {
        PM_IDLE    = 1'b0,
        PM_MEASURE = 1'b1
    } pm_state_t;

    localparam int          PM_CNT_W   = 28;
    localparam logic [27:0] PM_TIMEOUT = 28'd100000000;

endpackage : period_meter_pkg

`default_nettype wire

// File: rtl/period_meter_edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Optional 2-flop synchronizer (PERIOD_METER_SYNC_EN) plus
//               rise/fall detection of the conditioned input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync
    import period_meter_pkg::*;
(
    input  logic clock_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise_det,
    output logic fall_det
);

    logic w_s;
    logic r_s_d;

`ifdef PERIOD_METER_SYNC_EN
    logic r_sync1;
    logic r_s;

    // Flops preset to 1 so that reset release cannot look like a rising edge.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_s     <= 1'b1;
        end else begin
            r_sync1 <= sig_in;
            r_s     <= r_sync1;
        end
    end

    assign w_s = r_s;
`else
    assign w_s = sig_in;
`endif

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_s_d <= 1'b1;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign rise_det = w_s & ~r_s_d;
    assign fall_det = ~w_s & r_s_d;

endmodule : edge_sync

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// Module      : period_meter
// Description : Measures period and high time of a slow square wave in
//               clock_in cycles; build option PERIOD_METER_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter
    import period_meter_pkg::*;
#(
    parameter int               CNT_W          = PM_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(PM_TIMEOUT)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] high_cycles,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic w_rise;
    logic w_fall;

    pm_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_tmp;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_timeout;
    logic             r_busy;

    edge_sync u_edge_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .sig_in   (sig_in),
        .rise_det (w_rise),
        .fall_det (w_fall)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state      <= PM_IDLE;
            r_cnt        <= '0;
            r_hi_tmp     <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                PM_IDLE: begin
                    // First edge only arms the measurement; no result yet.
                    if (w_rise) begin
                        r_cnt   <= c_CNT_ONE;
                        r_state <= PM_MEASURE;
                        r_busy  <= 1'b1;
                    end
                end
                PM_MEASURE: begin
                    if (w_fall) begin
                        r_hi_tmp <= r_cnt;
                    end
                    // A rise coinciding with the timeout count wins, so the
                    // counter can never pass TIMEOUT_CYCLES.
                    if (w_rise) begin
                        r_period     <= r_cnt;
                        r_high       <= r_hi_tmp;
                        r_meas_valid <= 1'b1;
                        r_cnt        <= c_CNT_ONE;
                    end else if (r_cnt == TIMEOUT_CYCLES) begin
                        r_timeout <= 1'b1;
                        r_state   <= PM_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= PM_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign period_cycles = r_period;
    assign high_cycles   = r_high;
    assign meas_valid    = r_meas_valid;
    assign timeout       = r_timeout;
    assign busy          = r_busy;

endmodule : period_meter

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module      : tb_period_meter
// Description : Scoreboard bench for period_meter (TIMEOUT_CYCLES = 100).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_meter;

    localparam int CNT_W = 28;
`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        bit is_to;
        int p;
        int h;
        int c0;
    } exp_t;

    logic             clock_in = 1'b0;
    logic             reset    = 1'b1;
    logic             sig_in   = 1'b0;
    logic [CNT_W-1:0] period_cycles;
    logic [CNT_W-1:0] high_cycles;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_p   = 0;
    int   last_h   = 0;

    period_meter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (28'd100)
    ) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .sig_in        (sig_in),
        .period_cycles (period_cycles),
        .high_cycles   (high_cycles),
        .meas_valid    (meas_valid),
        .timeout       (timeout),
        .busy          (busy)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc++;

    // Monitor: every meas_valid/timeout pulse is matched against the queue.
    always @(negedge clock_in) begin
        exp_t e;
        if (meas_valid || timeout) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: meas_valid=%0b timeout=%0b period=%0d high=%0d, required no event",
                         meas_valid, timeout, period_cycles, high_cycles);
            end else begin
                e = q.pop_front();
                if (e.is_to) begin
                    if (!timeout || meas_valid) begin
                        failures++;
                        $display("FAIL timeout_event: meas_valid=%0b timeout=%0b, required timeout only",
                                 meas_valid, timeout);
                    end
                end else begin
                    if (!meas_valid || timeout || period_cycles != CNT_W'(e.p) || high_cycles != CNT_W'(e.h)) begin
                        failures++;
                        $display("FAIL result: mv=%0b to=%0b period=%0d high=%0d, required mv=1 to=0 period=%0d high=%0d",
                                 meas_valid, timeout, period_cycles, high_cycles, e.p, e.h);
                    end
                    checks++;
                    if (cyc - e.c0 != LAT) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - e.c0, LAT);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // One input period; every rise after the first closes the previous period.
    task automatic period(input int p, input int h, input bit first);
        if (!first) q.push_back('{1'b0, last_p, last_h, cyc});
        sig_in = 1'b1;
        wait_cyc(h);
        sig_in = 1'b0;
        wait_cyc(p - h);
        last_p = p;
        last_h = h;
    endtask

    task automatic stall();
        q.push_back('{1'b1, 0, 0, cyc});
        sig_in = 1'b0;
        wait_cyc(120);
    endtask

    task automatic check_out(input string name, input int p, input int h, input bit b);
        checks++;
        if (period_cycles != CNT_W'(p) || high_cycles != CNT_W'(h) || busy != b || meas_valid || timeout) begin
            failures++;
            $display("FAIL %s: period=%0d high=%0d busy=%0b mv=%0b to=%0b, required period=%0d high=%0d busy=%0b mv=0 to=0",
                     name, period_cycles, high_cycles, busy, meas_valid, timeout, p, h, b);
        end
    endtask

    initial begin
        wait_cyc(3);
        reset = 1'b0;
        check_out("reset_state", 0, 0, 1'b0);
        wait_cyc(3);

        // 50/25 for four periods, then stall
        period(50, 25, 1'b1);
        check_out("busy_after_first_rise", 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) period(50, 25, 1'b0);
        stall();
        check_out("hold_after_timeout", 50, 25, 1'b0);

        // 20/5 switching to 8/6
        period(20, 5, 1'b1);
        for (int i = 0; i < 2; i++) period(20, 5, 1'b0);
        for (int i = 0; i < 3; i++) period(8, 6, 1'b0);
        stall();
        check_out("hold_after_switch", 8, 6, 1'b0);

        // rise exactly at cnt == TIMEOUT_CYCLES
        period(100, 50, 1'b1);
        period(10, 5, 1'b0);
        stall();
        check_out("max_period_hold", 100, 50, 1'b0);

        // reset midway through a period
        period(50, 25, 1'b1);
        q.push_back('{1'b0, 50, 25, cyc});
        sig_in = 1'b1;
        wait_cyc(25);
        sig_in = 1'b0;
        wait_cyc(10);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_out("mid_reset", 0, 0, 1'b0);
        wait_cyc(15);
        period(50, 25, 1'b1);
        period(50, 25, 1'b0);
        stall();
        check_out("after_mid_reset", 50, 25, 1'b0);

        // fastest legal input: toggle every cycle
        period(2, 1, 1'b1);
        for (int i = 0; i < 5; i++) period(2, 1, 1'b0);
        stall();
        check_out("toggle_hold", 2, 1, 1'b0);

        wait_cyc(10);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: %0d outstanding, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_period_meter

`default_nettype wire
